// File: rtl/cfg_sram_crc.sv
// cfg_sram_crc: scan-loadable configuration memory with a random-access port
// and a frame-aware serial load controller that checks a CRC-8 trailer.
module cfg_sram_crc #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 1
) (
    input  logic                  scan_clk,
    input  logic                  scan_rst,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata,
    input  logic                  scan_en,
    input  logic                  scan_in,
    output logic                  scan_out,
    output logic                  cfg_busy,
    output logic                  cfg_done,
    output logic                  cfg_err
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int N = DEPTH * DATA_WIDTH;
    localparam int CNT_W = $clog2(N + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(N - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_TRAIL,
        S_DONE,
        S_ERR
    } state_t;

    state_t                r_state;
    logic [N-1:0]          r_store;
    logic [7:0]            r_crc;
    logic [CNT_W-1:0]      r_bit_cnt;
    logic [2:0]            r_trl_cnt;

    logic [7:0]            w_crc_next;
    logic [7:0]            w_crc_start;
    logic [DATA_WIDTH-1:0] w_rdata;

    // MSB-first CRC-8, polynomial x^8 + x^2 + x + 1.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
        logic fb;
        fb = crc[7] ^ din;
        return {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    endfunction

    assign w_crc_next  = crc8_step(r_crc, scan_in);
    assign w_crc_start = crc8_step(8'h00, scan_in);

    always_comb begin
        w_rdata = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (raddr == ADDR_WIDTH'(i)) begin
                w_rdata = r_store[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge scan_clk) begin
        if (scan_rst) begin
            r_state   <= S_IDLE;
            r_store   <= '0;
            r_crc     <= 8'h00;
            r_bit_cnt <= '0;
            r_trl_cnt <= 3'd0;
        end else begin
            case (r_state)
                S_SHIFT: begin
                    if (scan_en) begin
                        r_store <= {r_store[N-2:0], scan_in};
                        r_crc   <= w_crc_next;
                        if (r_bit_cnt == LAST_BIT) begin
                            r_bit_cnt <= '0;
                            r_state   <= S_TRAIL;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                end
                S_TRAIL: begin
                    // Trailer bits feed the CRC only; storage holds the frame data.
                    if (scan_en) begin
                        r_crc <= w_crc_next;
                        if (r_trl_cnt == 3'd7) begin
                            r_trl_cnt <= 3'd0;
                            r_state   <= (w_crc_next == 8'h00) ? S_DONE : S_ERR;
                        end else begin
                            r_trl_cnt <= r_trl_cnt + 3'd1;
                        end
                    end
                end
                default: begin
                    // Idle-like states: a random-access write beats a frame start.
                    if (we) begin
                        for (int i = 0; i < DEPTH; i++) begin
                            if (waddr == ADDR_WIDTH'(i)) begin
                                r_store[i*DATA_WIDTH +: DATA_WIDTH] <= wdata;
                            end
                        end
                    end else if (scan_en) begin
                        r_store   <= {r_store[N-2:0], scan_in};
                        r_crc     <= w_crc_start;
                        r_bit_cnt <= CNT_W'(1);
                        r_trl_cnt <= 3'd0;
                        r_state   <= S_SHIFT;
                    end
                end
            endcase
        end
    end

    assign rdata    = w_rdata;
    assign scan_out = r_store[N-1];
    assign cfg_busy = (r_state == S_SHIFT) || (r_state == S_TRAIL);
    assign cfg_done = (r_state == S_DONE);
    assign cfg_err  = (r_state == S_ERR);

endmodule

// File: tb/tb_cfg_sram_crc.sv
// Bench for cfg_sram_crc: two instances (16x1 and 4x4) checked every cycle
// against a frame-level model, plus hand-computed literal expectations.
module tb_cfg_sram_crc;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       a_we, a_en, a_in, a_so, a_busy, a_done, a_err;
    logic [3:0] a_waddr, a_raddr;
    logic [0:0] a_wdata, a_rdata;
    logic       b_we, b_en, b_in, b_so, b_busy, b_done, b_err;
    logic [1:0] b_waddr, b_raddr;
    logic [3:0] b_wdata, b_rdata;

    int n_checks = 0;
    int n_errors = 0;

    cfg_sram_crc #(.ADDR_WIDTH(4), .DATA_WIDTH(1)) dut_a (
        .scan_clk(clk), .scan_rst(rst), .we(a_we), .waddr(a_waddr), .wdata(a_wdata),
        .raddr(a_raddr), .rdata(a_rdata), .scan_en(a_en), .scan_in(a_in),
        .scan_out(a_so), .cfg_busy(a_busy), .cfg_done(a_done), .cfg_err(a_err)
    );

    cfg_sram_crc #(.ADDR_WIDTH(2), .DATA_WIDTH(4)) dut_b (
        .scan_clk(clk), .scan_rst(rst), .we(b_we), .waddr(b_waddr), .wdata(b_wdata),
        .raddr(b_raddr), .rdata(b_rdata), .scan_en(b_en), .scan_in(b_in),
        .scan_out(b_so), .cfg_busy(b_busy), .cfg_done(b_done), .cfg_err(b_err)
    );

    // Frame-level model: both instances hold 16 storage bits.
    logic [15:0] m_s    [2];
    int          m_n    [2];
    logic [23:0] m_bits [2];
    logic        m_done [2];
    logic        m_err  [2];

    // Remainder of the 24-bit frame polynomial divided by x^8+x^2+x+1.
    function automatic logic [7:0] poly_rem(input logic [23:0] m);
        logic [23:0] r;
        r = m;
        for (int i = 23; i >= 8; i--) begin
            if (r[i]) r = r ^ (24'h000107 << (i - 8));
        end
        return r[7:0];
    endfunction

    task automatic mdl_step(input int k, input logic r, input logic en, input logic bi,
                            input logic w, input int wa, input logic [3:0] wd, input int dw);
        if (r) begin
            m_s[k] = '0; m_n[k] = 0; m_bits[k] = '0; m_done[k] = 1'b0; m_err[k] = 1'b0;
        end else if (m_n[k] > 0) begin
            if (en) begin
                m_bits[k] = {m_bits[k][22:0], bi};
                m_n[k]++;
                if (m_n[k] <= 16) m_s[k] = {m_s[k][14:0], bi};
                if (m_n[k] == 24) begin
                    m_done[k] = (poly_rem(m_bits[k]) == 8'h00);
                    m_err[k]  = !m_done[k];
                    m_n[k]    = 0;
                end
            end
        end else if (w) begin
            for (int j = 0; j < dw; j++) m_s[k][wa*dw + j] = wd[j];
        end else if (en) begin
            m_done[k] = 1'b0; m_err[k] = 1'b0; m_n[k] = 1;
            m_bits[k] = {23'b0, bi};
            m_s[k] = {m_s[k][14:0], bi};
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Inputs change just after the falling edge, so here they still equal
    // the values the DUTs sampled on the preceding rising edge.
    initial begin
        forever begin
            @(negedge clk);
            mdl_step(0, rst, a_en, a_in, a_we, int'(a_waddr), {3'b000, a_wdata}, 1);
            mdl_step(1, rst, b_en, b_in, b_we, int'(b_waddr), b_wdata, 4);
            chk("a_rdata", a_rdata, m_s[0][a_raddr]);
            chk("a_scan_out", a_so, m_s[0][15]);
            chk("a_busy", a_busy, m_n[0] > 0);
            chk("a_done", a_done, m_done[0]);
            chk("a_err", a_err, m_err[0]);
            chk("b_rdata", b_rdata, m_s[1][int'(b_raddr)*4 +: 4]);
            chk("b_scan_out", b_so, m_s[1][15]);
            chk("b_busy", b_busy, m_n[1] > 0);
            chk("b_done", b_done, m_done[1]);
            chk("b_err", b_err, m_err[1]);
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic frame_a(input logic [15:0] d, input logic [7:0] t, input bit stall);
        logic [23:0] f;
        f = {d, t};
        for (int i = 23; i >= 0; i--) begin
            a_en = 1'b1; a_in = f[i]; a_we = 1'b0;
            step();
            if (i == 23) chk("busy_after_bit1", a_busy, 1);
            if (i == 1) begin
                chk("busy_before_last", a_busy, 1);
                chk("done_before_last", a_done, 0);
            end
            if (stall && i > 0) begin
                a_en = 1'b0; a_we = 1'b1; a_waddr = 4'd3; a_wdata = 1'b1;
                step();
                a_we = 1'b0;
            end
        end
        a_en = 1'b0;
    endtask

    task automatic frame_b(input logic [15:0] d, input logic [7:0] t);
        logic [23:0] f;
        f = {d, t};
        for (int i = 23; i >= 0; i--) begin
            b_en = 1'b1; b_in = f[i]; b_we = 1'b0;
            step();
        end
        b_en = 1'b0;
    endtask

    task automatic read_a(input logic [15:0] exp, input string nm);
        for (int a = 0; a < 16; a++) begin
            a_raddr = 4'(a);
            step();
            chk(nm, a_rdata, exp[a]);
        end
        a_raddr = 4'd0;
    endtask

    initial begin
        rst = 1'b1;
        a_we = 0; a_en = 0; a_in = 0; a_waddr = 0; a_wdata = 0; a_raddr = 0;
        b_we = 0; b_en = 0; b_in = 0; b_waddr = 0; b_wdata = 0; b_raddr = 0;
        step();
        step();
        chk("rst_rdata", a_rdata, 0);
        chk("rst_scan_out", a_so, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_done", a_done, 0);
        chk("rst_err", a_err, 0);
        chk("model_rem_0001_07", poly_rem(24'h000107), 8'h00);
        chk("model_rem_0001_06", poly_rem(24'h000106), 8'h01);
        chk("model_rem_a5c3_1e", poly_rem(24'hA5C31E), 8'h00);
        rst = 1'b0;
        step();

        // Good frame of zeros
        frame_a(16'h0000, 8'h00, 1'b0);
        chk("t1_done", a_done, 1);
        chk("t1_busy", a_busy, 0);
        chk("t1_err", a_err, 0);
        read_a(16'h0000, "t1_word");

        // Good frame, one bit set
        frame_a(16'h0001, 8'h07, 1'b0);
        chk("t2_done", a_done, 1);
        chk("t2_scan_out", a_so, 0);
        read_a(16'h0001, "t2_word");

        // Bad CRC, then recovery with a good frame
        frame_a(16'h0001, 8'h06, 1'b0);
        chk("t3_err", a_err, 1);
        chk("t3_done", a_done, 0);
        read_a(16'h0001, "t3_word");
        frame_a(16'h0001, 8'h07, 1'b0);
        chk("t3_recover_err", a_err, 0);
        chk("t3_recover_done", a_done, 1);

        // Stalls with writes attempted while busy
        frame_a(16'h0001, 8'h07, 1'b1);
        chk("t4_done", a_done, 1);
        chk("t4_err", a_err, 0);
        read_a(16'h0001, "t4_word");

        // Wider words on the 4x4 instance
        frame_b(16'hA5C3, 8'h1E);
        chk("t5_done", b_done, 1);
        for (int a = 0; a < 4; a++) begin
            logic [15:0] exp_words;
            exp_words = 16'hA5C3;
            b_raddr = 2'(a);
            step();
            chk("t5_word", b_rdata, exp_words[a*4 +: 4]);
        end

        // Reset mid-frame, then write beats a simultaneous scan bit
        for (int i = 0; i < 9; i++) begin
            a_en = 1'b1; a_in = 1'b1;
            step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0; a_en = 1'b0;
        chk("t6_busy", a_busy, 0);
        chk("t6_done", a_done, 0);
        chk("t6_err", a_err, 0);
        chk("t6_scan_out", a_so, 0);
        chk("t6_b_done", b_done, 0);
        read_a(16'h0000, "t6_cleared");
        a_we = 1'b1; a_en = 1'b1; a_in = 1'b1; a_waddr = 4'd5; a_wdata = 1'b1;
        step();
        chk("t6_wr_busy", a_busy, 0);
        a_we = 1'b0; a_en = 1'b0;
        step();
        chk("t6_wr_still_idle", a_busy, 0);
        read_a(16'h0020, "t6_word");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
